// File: rtl/bullet_line_scan.sv
// Per-scanline bullet renderer: scans the bullet table during hblank into a back buffer, swaps at DONE, draws a 1-bit pixel.
// Optional macro BULLET_LINE_SCAN_OVF_EN enables the ovf flag (otherwise ovf is tied low).
module bullet_line_scan #(
    parameter int          NUM_BULLETS = 8,
    parameter logic [10:0] BASE_ADDR   = 11'h000,
    parameter int          MAX_HITS    = 4,
    parameter int          BULLET_W    = 2,
    parameter int          BULLET_H    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hblank_start,
    input  logic [7:0]  line_y,
    input  logic        active,
    input  logic [7:0]  pix_x,
    output logic [10:0] ram_addr,
    input  logic [7:0]  ram_q,
    output logic        bullet_pix,
    output logic        busy,
    output logic        ovf
);
    localparam int            CW        = $clog2(MAX_HITS + 1);
    localparam logic [8:0]    BW9       = 9'(BULLET_W);
    localparam logic [8:0]    BH9       = 9'(BULLET_H);
    localparam logic [3:0]    LAST_IDX  = 4'(NUM_BULLETS - 1);
    localparam logic [CW-1:0] HIT_LIMIT = CW'(MAX_HITS);

    typedef enum logic [2:0] {IDLE, RD_Y, WT_Y, CK_Y, RD_X, WT_X, ST_X, DONE} state_t;

    state_t        state_reg, state_next;
    logic [3:0]    idx_reg, idx_next;
    logic [10:0]   ram_addr_reg, ram_addr_next;
    logic [7:0]    line_y_reg;
    logic [CW-1:0] hit_cnt_reg;
    logic          bullet_pix_reg;
    logic          start_scan, advance, store_x, do_swap;
    logic [7:0]    y_diff;
    logic          y_hit, slot_free, last_entry;
    logic [MAX_HITS-1:0] pix_hit;

    // Y compare is modulo 256 so bullets straddling line 255 -> 0 still hit.
    assign y_diff     = line_y_reg - ram_q;
    assign y_hit      = (ram_q != 8'hFF) && ({1'b0, y_diff} < BH9);
    assign slot_free  = (hit_cnt_reg < HIT_LIMIT);
    assign last_entry = (idx_reg == LAST_IDX);

    always_comb begin
        state_next = state_reg;
        start_scan = 1'b0;
        advance    = 1'b0;
        store_x    = 1'b0;
        do_swap    = 1'b0;
        case (state_reg)
            IDLE: state_next = IDLE;
            RD_Y: state_next = WT_Y;
            WT_Y: state_next = CK_Y;
            CK_Y: begin
                if (y_hit && slot_free) state_next = RD_X;
                else                    advance    = 1'b1;
            end
            RD_X: state_next = WT_X;
            WT_X: state_next = ST_X;
            ST_X: begin
                store_x = 1'b1;
                advance = 1'b1;
            end
            DONE: begin
                do_swap    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (advance) state_next = last_entry ? DONE : RD_Y;
        // A new hblank always wins; in DONE the swap still completes.
        if (hblank_start) begin
            start_scan = 1'b1;
            advance    = 1'b0;
            store_x    = 1'b0;
            state_next = RD_Y;
        end

        idx_next = idx_reg;
        if (start_scan)                   idx_next = 4'd0;
        else if (advance && !last_entry)  idx_next = idx_reg + 4'd1;

        // Address is issued on entry to RD_Y/RD_X so data lands in CK_Y/ST_X.
        ram_addr_next = ram_addr_reg;
        if (state_next == RD_Y)      ram_addr_next = BASE_ADDR + {6'd0, idx_next, 1'b1};
        else if (state_next == RD_X) ram_addr_next = BASE_ADDR + {6'd0, idx_reg, 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            idx_reg        <= 4'd0;
            ram_addr_reg   <= BASE_ADDR;
            line_y_reg     <= 8'd0;
            hit_cnt_reg    <= '0;
            bullet_pix_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            ram_addr_reg   <= ram_addr_next;
            bullet_pix_reg <= active && (|pix_hit);
            if (start_scan) begin
                line_y_reg  <= line_y;
                hit_cnt_reg <= '0;
            end else if (store_x) begin
                hit_cnt_reg <= hit_cnt_reg + CW'(1);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < MAX_HITS; gi++) begin : g_slot
            logic [7:0] back_x_reg, front_x_reg;
            logic       back_v_reg, front_v_reg;
            logic [7:0] dx;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    back_x_reg  <= 8'd0;
                    back_v_reg  <= 1'b0;
                    front_x_reg <= 8'd0;
                    front_v_reg <= 1'b0;
                end else begin
                    if (start_scan) begin
                        back_v_reg <= 1'b0;
                    end else if (store_x && (hit_cnt_reg == CW'(gi))) begin
                        back_v_reg <= 1'b1;
                        back_x_reg <= ram_q;
                    end
                    if (do_swap) begin
                        front_v_reg <= back_v_reg;
                        front_x_reg <= back_x_reg;
                    end
                end
            end

            // Horizontal span also wraps 255 -> 0 on purpose.
            assign dx          = pix_x - front_x_reg;
            assign pix_hit[gi] = front_v_reg && ({1'b0, dx} < BW9);
        end
    endgenerate

`ifdef BULLET_LINE_SCAN_OVF_EN
    logic ovf_pend_reg, ovf_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_pend_reg <= 1'b0;
            ovf_reg      <= 1'b0;
        end else begin
            if (start_scan)
                ovf_pend_reg <= 1'b0;
            else if ((state_reg == CK_Y) && y_hit && !slot_free)
                ovf_pend_reg <= 1'b1;
            if (do_swap) ovf_reg <= ovf_pend_reg;
        end
    end

    assign ovf = ovf_reg;
`else
    assign ovf = 1'b0;
`endif

    assign ram_addr   = ram_addr_reg;
    assign bullet_pix = bullet_pix_reg;
    assign busy       = (state_reg != IDLE);
endmodule

// File: tb/tb_bullet_line_scan.sv
// Randomized bench for bullet_line_scan against a queue-based model of the bullet table and front buffer.
`timescale 1ns/1ps
module tb_bullet_line_scan;
    localparam int          NB   = 8;
    localparam logic [10:0] BASE = 11'h000;
    localparam int          MH   = 4;
    localparam int          BW   = 2;
    localparam int          BH   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hblank_start = 1'b0;
    logic [7:0]  line_y = 8'd0;
    logic        active = 1'b0;
    logic [7:0]  pix_x = 8'd0;
    logic [10:0] ram_addr;
    logic [7:0]  ram_q, ram_q1;
    logic        bullet_pix, busy, ovf;

    logic [7:0]  mem [0:2047];

    int vectors = 0;
    int miscompares = 0;
    int front_q[$];
    int next_q[$];
    int saved_q[$];
    bit ovf_exp = 1'b0;
    bit next_ovf, saved_ovf;
    int next_len;
    bit pend_exp = 1'b0;

    bullet_line_scan #(
        .NUM_BULLETS(NB), .BASE_ADDR(BASE), .MAX_HITS(MH), .BULLET_W(BW), .BULLET_H(BH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hblank_start(hblank_start), .line_y(line_y),
        .active(active), .pix_x(pix_x), .ram_addr(ram_addr), .ram_q(ram_q),
        .bullet_pix(bullet_pix), .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Bullet RAM port B: data valid two clocks after the address changes.
    always @(posedge clk) begin
        ram_q1 <= mem[ram_addr];
        ram_q  <= ram_q1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Which bullets the scan should keep for scanline ly, straight from the table rules.
    function automatic void model_scan(input logic [7:0] ly);
        logic [7:0] y, d;
        next_q.delete();
        next_ovf = 1'b0;
        for (int i = 0; i < NB; i++) begin
            y = mem[32'(BASE) + 2*i + 1];
            d = ly - y;
            if (y != 8'hFF && d < BH) begin
                if (next_q.size() < MH) next_q.push_back(int'(mem[32'(BASE) + 2*i]));
                else                    next_ovf = 1'b1;
            end
        end
        next_len = 3*NB + 3*next_q.size() + 1;
    endfunction

    function automatic bit model_pix(input bit act, input logic [7:0] px);
        logic [7:0] d;
        bit hit;
        hit = 1'b0;
        if (act) foreach (front_q[k]) begin
            d = px - 8'(front_q[k]);
            if (d < BW) hit = 1'b1;
        end
        return hit;
    endfunction

    task automatic commit(input int q[$], input bit o);
        front_q = q;
`ifdef BULLET_LINE_SCAN_OVF_EN
        ovf_exp = o;
`else
        ovf_exp = 1'b0;
        if (o) ovf_exp = 1'b0;
`endif
    endtask

    task automatic drive_pix(input bit act, input logic [7:0] px);
        active   = act;
        pix_x    = px;
        pend_exp = model_pix(act, px);
    endtask

    task automatic rand_pix();
        logic [7:0] px;
        if (front_q.size() > 0 && $urandom_range(0, 1) == 1)
            px = 8'(front_q[$urandom_range(0, front_q.size() - 1)] + int'($urandom_range(0, 2)));
        else
            px = 8'($urandom);
        drive_pix($urandom_range(0, 3) != 0, px);
    endtask

    task automatic step_pix(input string tag);
        @(negedge clk);
        check(tag, 32'(bullet_pix), 32'(pend_exp));
    endtask

    task automatic start_scan(input logic [7:0] ly);
        model_scan(ly);
        hblank_start = 1'b1;
        line_y       = ly;
        rand_pix();
        @(negedge clk);
        hblank_start = 1'b0;
        line_y       = 8'($urandom);
        check("pix_at_start", 32'(bullet_pix), 32'(pend_exp));
        check("busy_at_start", 32'(busy), 32'd1);
        check("addr_first_y", 32'(ram_addr), 32'(BASE) + 32'd1);
    endtask

    task automatic wait_done();
        int cnt;
        cnt = 1;
        while (busy === 1'b1 && cnt < 300) begin
            rand_pix();
            step_pix("pix_during_scan");
            if (busy === 1'b1) begin
                cnt++;
                check("ovf_hold", 32'(ovf), 32'(ovf_exp));
            end
        end
        check("busy_len", 32'(cnt), 32'(next_len));
        commit(next_q, next_ovf);
        check("ovf_after_done", 32'(ovf), 32'(ovf_exp));
        active = 1'b0;
    endtask

    task automatic sweep(input bit all_active);
        for (int p = 0; p < 256; p++) begin
            drive_pix(all_active ? 1'b1 : ($urandom_range(0, 3) != 0), 8'(p));
            step_pix("pix_sweep");
        end
        active = 1'b0;
    endtask

    task automatic clear_table();
        for (int i = 0; i < NB; i++) begin
            mem[32'(BASE) + 2*i]     = 8'($urandom);
            mem[32'(BASE) + 2*i + 1] = 8'hFF;
        end
    endtask

    task automatic set_entry(input int i, input logic [7:0] x, input logic [7:0] y);
        mem[32'(BASE) + 2*i]     = x;
        mem[32'(BASE) + 2*i + 1] = y;
    endtask

    task automatic rand_table(input logic [7:0] ly);
        for (int i = 0; i < NB; i++) begin
            case ($urandom_range(0, 3))
                0:       set_entry(i, 8'($urandom), 8'hFF);
                1:       set_entry(i, 8'($urandom), 8'($urandom));
                default: set_entry(i, 8'($urandom), ly - 8'($urandom_range(0, 2)));
            endcase
        end
    endtask

    initial begin
        logic [7:0] ly;
        for (int a = 0; a < 2048; a++) mem[a] = 8'hFF;

        // Reset and idle
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pix", 32'(bullet_pix), 32'd0);
        rst_n = 1'b1;
        for (int c = 0; c < 100; c++) begin
            rand_pix();
            active = 1'b1;
            pend_exp = model_pix(1'b1, pix_x);
            step_pix("idle_pix");
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_ovf", 32'(ovf), 32'd0);
            check("idle_addr", 32'(ram_addr), 32'(BASE));
        end
        active = 1'b0;

        // Single bullet, hit then miss by one line
        clear_table();
        set_entry(0, 8'h40, 8'h20);
        start_scan(8'h21); wait_done(); sweep(1'b1);
        start_scan(8'h22); wait_done(); sweep(1'b1);

        // Unused-slot marker and wrap in both axes
        clear_table();
        set_entry(0, 8'hFF, 8'hFE);
        start_scan(8'h00); wait_done(); sweep(1'b1);
        start_scan(8'hFF); wait_done(); sweep(1'b1);

        // More hits than slots
        clear_table();
        for (int i = 0; i < 6; i++) set_entry(i, 8'(8'h80 + 8*i), 8'h10);
        start_scan(8'h10); wait_done(); sweep(1'b1);

        // Abort 10 clocks into a scan: front and ovf retained until the restarted scan finishes
        set_entry(6, 8'h30, 8'h50);
        set_entry(7, 8'h31, 8'h50);
        start_scan(8'h10);
        repeat (9) begin
            rand_pix();
            step_pix("pix_abort");
            check("ovf_abort", 32'(ovf), 32'(ovf_exp));
        end
        start_scan(8'h50); wait_done(); sweep(1'b1);

        // hblank_start landing in DONE
        ly = 8'h77;
        rand_table(ly);
        start_scan(ly);
        saved_q = next_q;
        saved_ovf = next_ovf;
        for (int c = 0; c < next_len - 1; c++) begin
            rand_pix();
            step_pix("pix_pre_done");
        end
        check("busy_in_done", 32'(busy), 32'd1);
        start_scan(ly + 8'd1);
        commit(saved_q, saved_ovf);
        check("ovf_done_swap", 32'(ovf), 32'(ovf_exp));
        wait_done(); sweep(1'b0);

        // Randomized tables and lines
        for (int r = 0; r < 20; r++) begin
            ly = 8'($urandom);
            rand_table(ly);
            start_scan(ly); wait_done(); sweep(1'b0);
        end

        // Reset mid-scan with bullets in the front buffer
        clear_table();
        set_entry(2, 8'h60, 8'h33);
        start_scan(8'h33); wait_done();
        start_scan(8'h90);
        repeat (5) begin
            drive_pix(1'b1, 8'(front_q[0]));
            step_pix("pix_before_rst");
        end
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_pix", 32'(bullet_pix), 32'd0);
        check("midrst_addr", 32'(ram_addr), 32'(BASE));
        check("midrst_ovf", 32'(ovf), 32'd0);
        front_q.delete();
        ovf_exp = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sweep(1'b1);
        check("post_rst_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bullet_line_scan.md
# bullet_line_scan

Per-scanline bullet renderer for the Tank Battalion video path: sits directly downstream of the bullet table RAM (read-only use of its registered read port B). During each horizontal blank it walks the bullet table, picks up to MAX_HITS bullets that intersect the upcoming scanline into a back buffer, then swaps buffers and drives a 1-bit bullet pixel during active video.

## Interface
- NUM_BULLETS, 8, table entries scanned per line (1..16)
- BASE_ADDR, 11'h000, RAM address of entry 0; entry i = {X at BASE_ADDR+2i, Y at BASE_ADDR+2i+1}
- MAX_HITS, 4, bullets drawable on one line
- BULLET_W, 2, bullet width in pixels
- BULLET_H, 2, bullet height in lines

- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active-low
- hblank_start  in  1  one-clock pulse at start of horizontal blank
- line_y  in  8  scanline to be displayed after this blank; sampled on hblank_start
- active  in  1  active video
- pix_x  in  8  current pixel X during active
- ram_addr  out  11  read address to bullet RAM port B (registered)
- ram_q  in  8  RAM read data; valid 2 clocks after ram_addr changes
- bullet_pix  out  1  bullet pixel (registered)
- busy  out  1  scan in progress
- ovf  out  1  more than MAX_HITS bullets on the scanned line

## Operation
- FSM states: IDLE, RD_Y, WT_Y, CK_Y, RD_X, WT_X, ST_X, DONE.
- IDLE: on hblank_start, latch line_y, index i=0, clear back-buffer valids and ovf_pend, go RD_Y.
- RD_Y: ram_addr <= BASE_ADDR+2i+1 -> WT_Y -> CK_Y.
- CK_Y: y=ram_q; diff = line_y - y (8-bit, modulo 256). Hit iff y != 8'hFF and diff < BULLET_H. y=8'hFF means slot unused, always skipped. Hit with free slot -> RD_X; hit with buffer full -> set ovf_pend, next entry; miss -> next entry.
- RD_X: ram_addr <= BASE_ADDR+2i -> WT_X -> ST_X: store ram_q with valid=1 in next back slot, next entry.
- Next entry: i==NUM_BULLETS-1 -> DONE, else i+1 -> RD_Y.
- DONE: swap front/back, ovf <= ovf_pend, -> IDLE.
- Pixel: bullet_pix <= active && any valid front slot with (pix_x - x) mod 256 < BULLET_W. Wrap at X=255 -> 0 is deliberate.
- Write port of the RAM is never driven by this block.

## Timing
- Reset (async): state IDLE, ram_addr=BASE_ADDR, bullet_pix=0, busy=0, ovf=0, all front/back valids 0.
- busy=1 in every state except IDLE.
- Miss costs 3 clocks, hit 6 clocks; scan length = 3*NUM_BULLETS + 3*hits + 1 (DONE). Defaults, worst case 8 bullets with 4 stored: 37 clocks.
- Front buffer changes only in DONE; bullet_pix lags pix_x/active by 1 clock.
- hblank_start while busy: abort current scan, no swap, front retained, ovf unchanged, restart immediately from i=0 with new line_y.
- hblank_start in the DONE cycle: swap completes, new scan starts next clock.
- rst_n low mid-scan: immediate return to reset values; nothing swapped.

## Configuration
- BULLET_LINE_SCAN_OVF_EN defined: ovf behaves as above.
- Undefined: ovf tied 0, ovf_pend removed; excess hits silently dropped (same pixel output).

## Test plan
- Reset then idle: bullet_pix=0, busy=0, ovf=0, ram_addr=BASE_ADDR over 100 clocks.
- Entry 0 = X 8'h40, Y 8'h20, rest Y=8'hFF; hblank_start with line_y 8'h21 -> busy 28 clocks, then bullet_pix=1 only at pix_x 8'h40/8'h41 (1 clock later); line_y 8'h22 -> no pixels.
- Y 8'hFE, line_y 8'h00 -> miss; line_y 8'hFF -> hit. X 8'hFF -> pixels at pix_x 8'hFF and 8'h00.
- Six entries all on line_y 8'h10 -> only first four X values drawn; ovf=1 after DONE (0 with macro undefined).
- Second hblank_start 10 clocks into a scan -> previous front pixels persist, scan restarts (ram_addr returns to BASE_ADDR+1), swap occurs only after full restarted scan.
- rst_n pulsed low mid-scan -> busy=0, bullet_pix=0 and all valids cleared immediately.
